// File: rtl/sine_rom_arb_pkg.sv
// sine_rom_arb_pkg: shared widths, requester id type and pipeline entry for sine_rom_arbiter
package sine_rom_arb_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 10;
  localparam int N_REQ  = 2;
  typedef logic req_id_t;
  typedef struct packed {
    logic    v;
    req_id_t id;
  } pipe_ent_t;
  function automatic logic [N_REQ-1:0] id_onehot(input req_id_t id);
    return N_REQ'(1) << id;
  endfunction
endpackage

// File: rtl/sine_rom_arbiter_rsp_pipe.sv
// rsp_pipe: DEPTH-stage (valid, id) delay line matching the ROM read latency
//   clk, rst_n : clock, asynchronous active-low reset (clears all valids)
//   in         : entry entering the line this cycle
//   out        : entry leaving the line, DEPTH cycles later
module rsp_pipe
  import sine_rom_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  pipe_ent_t in,
  output pipe_ent_t out
);
  pipe_ent_t [DEPTH-1:0] stg;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stg <= '0;
    else begin
      stg[0] <= in;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  assign out = stg[DEPTH-1];
endmodule

// File: rtl/sine_rom_arbiter.sv
// sine_rom_arbiter: two-requester round-robin front end for an external sine table ROM
//   i_clk, i_arst_n   : clock, asynchronous active-low reset
//   i_req_valid       : per-requester request valid
//   o_req_ready       : combinational one-hot (or zero) grant
//   i_req_addr0/1     : requested ROM addresses
//   o_rom_address     : address to the external ROM, updated on handshake
//   i_rom_q           : ROM data, valid ROM_LATENCY cycles after o_rom_address
//   o_rsp_valid       : one-cycle per-requester response strobe, ROM_LATENCY+1 after handshake
//   o_rsp_data        : ROM word for the strobed requester, held otherwise
//   o_grantCount0/1   : saturating grant counters, present only with SINE_ROM_ARB_STATS_EN
module sine_rom_arbiter
  import sine_rom_arb_pkg::*;
#(
  parameter int ROM_LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic [N_REQ-1:0]  i_req_valid,
  output logic [N_REQ-1:0]  o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr0,
  input  logic [ADDR_W-1:0] i_req_addr1,
  output logic [N_REQ-1:0]  o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic [ADDR_W-1:0] o_rom_address,
  input  logic [DATA_W-1:0] i_rom_q
`ifdef SINE_ROM_ARB_STATS_EN
  ,
  output logic [15:0]       o_grantCount0,
  output logic [15:0]       o_grantCount1
`endif
);
  req_id_t   last;
  logic      hs;
  req_id_t   gid;
  pipe_ent_t iss, rsp;
  // On a tie the requester that was not granted last wins
  always_comb begin
    o_req_ready = !i_arst_n ? '0 : &i_req_valid ? (last ? 2'b01 : 2'b10) : i_req_valid;
    hs = |(i_req_valid & o_req_ready);
    gid = o_req_ready[1];
  end
  // iss marks the cycle o_rom_address carries a fresh grant; the pipe then
  // spans the ROM read so its output lines up with i_rom_q
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) begin
      last <= 1'b1;
      o_rom_address <= '0;
      iss <= '0;
    end else begin
      last <= hs ? gid : last;
      o_rom_address <= hs ? (gid ? i_req_addr1 : i_req_addr0) : o_rom_address;
      iss <= '{v: hs, id: gid};
    end
  rsp_pipe #(.DEPTH(ROM_LATENCY)) u_pipe (
    .clk  (i_clk),
    .rst_n(i_arst_n),
    .in   (iss),
    .out  (rsp)
  );
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) begin
      o_rsp_valid <= '0;
      o_rsp_data <= '0;
    end else begin
      o_rsp_valid <= rsp.v ? id_onehot(rsp.id) : '0;
      o_rsp_data <= rsp.v ? i_rom_q : o_rsp_data;
    end
`ifdef SINE_ROM_ARB_STATS_EN
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) begin
      o_grantCount0 <= '0;
      o_grantCount1 <= '0;
    end else begin
      if (hs && !gid && o_grantCount0 != 16'hFFFF) o_grantCount0 <= o_grantCount0 + 16'd1;
      if (hs && gid && o_grantCount1 != 16'hFFFF) o_grantCount1 <= o_grantCount1 + 16'd1;
    end
`endif
endmodule

// File: tb/tb_sine_rom_arbiter.sv
// tb_sine_rom_arbiter: randomized and directed self-checking bench with a queue-based response model
module tb_sine_rom_arbiter;
  localparam int LAT = 2;
  logic       clk = 0;
  logic       rst_n = 0;
  logic [1:0] valid = 0;
  logic [1:0] ready;
  logic [9:0] addr0 = 0, addr1 = 0;
  logic [1:0] rsp_valid;
  logic [9:0] rsp_data, rom_address, rom_q, rom_r1;
`ifdef SINE_ROM_ARB_STATS_EN
  logic [15:0] gc0, gc1;
`endif
  int checks = 0, errors = 0;

  sine_rom_arbiter #(.ROM_LATENCY(LAT)) dut (
    .i_clk        (clk),
    .i_arst_n     (rst_n),
    .i_req_valid  (valid),
    .o_req_ready  (ready),
    .i_req_addr0  (addr0),
    .i_req_addr1  (addr1),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_data   (rsp_data),
    .o_rom_address(rom_address),
    .i_rom_q      (rom_q)
`ifdef SINE_ROM_ARB_STATS_EN
    ,
    .o_grantCount0(gc0),
    .o_grantCount1(gc1)
`endif
  );

  always #5 clk = ~clk;

  // registered ROM, two cycles address-to-data
  always @(posedge clk) begin
    rom_r1 <= rom_address;
    rom_q <= rom_r1 ^ 10'h155;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // model: every accepted request yields one response LAT+1 edges later, in order
  typedef struct {int due; logic [1:0] oh; logic [9:0] d;} rsp_t;
  rsp_t q[$];
  int   cyc = 0;
  logic mlast = 1;
  logic [9:0] m_addr = 0, m_data = 0;
  logic [1:0] m_rv = 0;

  function automatic logic [1:0] m_ready();
    if (!rst_n) return 2'b00;
    if (valid == 2'b11) return mlast ? 2'b01 : 2'b10;
    return valid;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      mlast = 1;
      m_addr = 0;
      m_data = 0;
      m_rv = 0;
    end else begin
      logic [1:0] g;
      g = m_ready();
      cyc++;
      m_rv = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        m_rv = q[0].oh;
        m_data = q[0].d;
        void'(q.pop_front());
      end
      if (g != 0) begin
        m_addr = g[1] ? addr1 : addr0;
        q.push_back('{cyc + LAT + 1, g, m_addr ^ 10'h155});
        mlast = g[1];
      end
    end
  end

  always @(negedge clk) begin
    chk("ready", ready, m_ready());
    chk("rom_address", rom_address, m_addr);
    chk("rsp_valid", rsp_valid, m_rv);
    chk("rsp_data", rsp_data, m_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    valid = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  initial begin
    tick();
    chk("reset_rom_address", rom_address, 10'h000);
    chk("reset_rsp_valid", rsp_valid, 2'b00);
    chk("reset_ready", ready, 2'b00);
    tick();
    rst_n = 1;
    tick();
    // single request
    valid = 2'b01;
    addr0 = 10'h003;
    #1 chk("single_ready", ready, 2'b01);
    tick();
    valid = 0;
    chk("single_rom_address", rom_address, 10'h003);
    tick();
    tick();
    tick();
    chk("single_rsp_valid", rsp_valid, 2'b01);
    chk("single_rsp_data", rsp_data, 10'h156);
    tick();
    chk("single_strobe_once", rsp_valid, 2'b00);
    chk("single_data_hold", rsp_data, 10'h156);
    // tie after reset
    do_reset();
    valid = 2'b11;
    addr0 = 10'h010;
    addr1 = 10'h020;
    for (int i = 0; i < 4; i++) begin
      #1 chk("tie_ready", ready, (i % 2) ? 2'b10 : 2'b01);
      tick();
    end
    valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("tie_rsp_valid", rsp_valid, (i % 2) ? 2'b10 : 2'b01);
      chk("tie_rsp_data", rsp_data, (i % 2) ? 10'h175 : 10'h145);
      tick();
    end
    // streaming on requester 1
    for (int i = 0; i < 11; i++) begin
      valid = (i < 8) ? 2'b10 : 2'b00;
      addr1 = 10'(i);
      tick();
      if (i >= 3) begin
        chk("stream_rsp_valid", rsp_valid, 2'b10);
        chk("stream_rsp_data", rsp_data, 10'(i - 3) ^ 10'h155);
      end
    end
    // reset one cycle after a handshake
    valid = 2'b01;
    addr0 = 10'h005;
    tick();
    valid = 0;
    rst_n = 0;
    #1;
    chk("midrst_ready", ready, 2'b00);
    chk("midrst_rom_address", rom_address, 10'h000);
    chk("midrst_rsp_valid", rsp_valid, 2'b00);
    chk("midrst_rsp_data", rsp_data, 10'h000);
    tick();
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_rsp", rsp_valid, 2'b00);
    end
    // randomized traffic with occasional reset
    for (int i = 0; i < 2000; i++) begin
      valid = 2'($urandom);
      addr0 = 10'($urandom);
      addr1 = 10'($urandom);
      rst_n = ($urandom_range(0, 63) != 0);
      tick();
    end
    rst_n = 1;
    valid = 0;
    for (int i = 0; i < 6; i++) tick();
`ifdef SINE_ROM_ARB_STATS_EN
    do_reset();
    chk("stats_reset0", gc0, 16'h0000);
    valid = 2'b01;
    for (int i = 0; i < 70000; i++) tick();
    valid = 0;
    tick();
    chk("stats_count0", gc0, 16'hFFFF);
    chk("stats_count1", gc1, 16'h0000);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sine_rom_arbiter.md
SINE_ROM_ARBITER -- requirements
Module: sine_rom_arbiter

Interface
REQ-001 SHALL have parameter ROM_LATENCY, default 2, meaning cycles from o_rom_address change to valid i_rom_q; legal range 1..4.
REQ-002 SHALL have i_clk, input, 1, the single clock (CLOCK_50); one clock domain only.
REQ-003 SHALL have i_arst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have i_req_valid, input, 2, per-requester request valid (bit n = requester n).
REQ-005 SHALL have o_req_ready, output, 2, per-requester accept, one-hot or zero.
REQ-006 SHALL have i_req_addr0 and i_req_addr1, input, 10 each, requested ROM address.
REQ-007 SHALL have o_rsp_valid, output, 2, per-requester response strobe.
REQ-008 SHALL have o_rsp_data, output, 10, ROM word for the strobed requester.
REQ-009 SHALL have o_rom_address, output, 10, address to the 1024x10 sine table ROM.
REQ-010 SHALL have i_rom_q, input, 10, ROM read data.

Function
REQ-011 SHALL accept at most one request per cycle; handshake = i_req_valid[n] & o_req_ready[n] at a rising edge.
REQ-012 SHALL drive o_req_ready combinationally: single valid -> that requester; both valid -> requester not most recently granted (round-robin); none -> 2'b00.
REQ-013 SHALL update the last-granted pointer only on a handshake; after reset pointer = 1, so requester 0 wins the first tie.
REQ-014 SHALL register the granted address into o_rom_address on the handshake edge; o_rom_address holds its value when no handshake occurs.
REQ-015 SHALL carry (valid, requester id) through a ROM_LATENCY-deep shift pipeline aligned with the ROM read.
REQ-016 SHALL register i_rom_q into o_rsp_data and assert o_rsp_valid[id] for exactly one cycle, ROM_LATENCY+1 cycles after the handshake edge.
REQ-017 SHALL sustain one response per cycle (full throughput), with responses returned in grant order.
REQ-018 SHALL hold o_rsp_data at its last value when o_rsp_valid = 0.
REQ-019 SHALL tolerate a requester changing its address while valid and not granted; the address sampled is the one present on the handshake edge.
REQ-020 SHALL ignore a requester with valid low: no grant, no pointer change.

Reset
REQ-021 SHALL, on i_arst_n low, immediately clear o_rom_address = 0, o_rsp_valid = 0, o_rsp_data = 0, all pipeline valids = 0, and pointer = 1.
REQ-022 SHALL discard in-flight requests when reset asserts mid-operation; no o_rsp_valid for them after reset release.
REQ-023 SHALL hold o_req_ready = 0 while i_arst_n is low.

Configuration
REQ-024 SHALL, when SINE_ROM_ARB_STATS_EN is defined, add outputs o_grantCount0 and o_grantCount1 (16 bits each), reset 0, incremented on each handshake of that requester, saturating at 0xFFFF.
REQ-025 SHALL, when SINE_ROM_ARB_STATS_EN is undefined, have neither the ports nor the counter logic; all other behaviour is identical.

Structure
REQ-026 SHALL take ADDR_W = 10, DATA_W = 10, N_REQ = 2 and the requester-id typedef from package sine_rom_arb_pkg.
REQ-027 SHALL implement the (valid, id) delay line as sub-module rsp_pipe, parameterised by depth ROM_LATENCY.
REQ-028 SHALL contain no ROM instance; the ROM is instantiated beside this block at top level.

Verification
Bench ROM model: registered, ROM_LATENCY = 2, q = addr ^ 10'h155.
REQ-029 SHALL cover a single request: requester 0 valid, addr 10'h003 -> ready[0] = 1 same cycle; o_rom_address = 10'h003 next cycle; o_rsp_valid = 2'b01 with data 10'h156 three cycles after the handshake.
REQ-030 SHALL cover a tie after reset: both valid, addr0 = 10'h010, addr1 = 10'h020 -> grants 0, 1, 0, 1 on consecutive cycles; responses 10'h145 (rsp_valid 01), then 10'h175 (rsp_valid 10), alternating.
REQ-031 SHALL cover streaming: requester 1 valid for 8 cycles with addr = 0..7 -> 8 consecutive o_rsp_valid = 2'b10 cycles with data 10'h155..10'h152 pattern (addr ^ 10'h155) in order.
REQ-032 SHALL cover reset mid-flight: handshake at cycle t, i_arst_n low at t+1 for one cycle -> no o_rsp_valid ever seen for that request; all outputs 0 during reset.
REQ-033 SHALL cover the stats build: with SINE_ROM_ARB_STATS_EN, 70000 grants to requester 0 -> o_grantCount0 = 16'hFFFF, o_grantCount1 = 0.
